// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds FSM state encoding, word/offset widths and latency counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OFFW = 2;
  localparam int unsigned CNTW = 4;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM, registered read data, no reset.
// Read register only loads when re_i is high so the value is held.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic            re_i,
  input  logic [AW-1:0]   idx_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] rdata_q;

  // Write port and held read register
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder with modelled access latency.
// Optional misalignment error: define DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [XLEN-1:0] LIMIT = XLEN'(DEPTH * 4);
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(LATENCY - 1);

  state_e          state_q;
  logic [CNTW-1:0] cnt_q;
  logic            we_q;
  logic            err_q;
  logic [AW-1:0]   idx_q;
  logic [XLEN-1:0] wdata_q;
  logic            ready_q;
  logic            valid_q;
  logic            rsp_err_q;
  logic            rd_ok_q;

  logic            req_err;
  logic            done;
  logic            ram_we;
  logic            ram_re;
  logic [XLEN-1:0] ram_rdata;

  // Request error: range check, plus alignment when enabled
  always_comb begin
    req_err = (req_addr_i >= LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
    req_err = req_err | (req_addr_i[OFFW-1:0] != '0);
`else
    req_err = req_err | 1'b0;
`endif
  end

  assign done   = (state_q == BUSY) && (cnt_q == '0);
  assign ram_we = done & we_q & ~err_q;
  assign ram_re = done & ~we_q & ~err_q;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // Access FSM with latency counter and registered handshake outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      rsp_err_q <= 1'b0;
      rd_ok_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            state_q <= BUSY;
            ready_q <= 1'b0;
            cnt_q   <= CNT_INIT;
            we_q    <= req_we_i;
            err_q   <= req_err;
            idx_q   <= req_addr_i[AW+OFFW-1:OFFW];
            wdata_q <= req_wdata_i;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q   <= RESP;
            valid_q   <= 1'b1;
            rsp_err_q <= err_q;
            rd_ok_q   <= ~we_q & ~err_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rd_ok_q ? ram_rdata : '0;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Handshaked data-memory responder serving load/store requests from the pipelined CPU's MEM stage (the CPU initiates, this block responds). It accepts one word request at a time, models a configurable access latency with a counter-driven FSM, commits writes, and returns read data or an error on a valid/ready response channel. It stalls the pipeline through `req_ready_o` and `rsp_valid_o`, with no fixed single-cycle access.

## Interface
- `DEPTH`, 256: memory size in 32-bit words (power of two, ≥ 4).
- `LATENCY`, 2: cycles spent in BUSY per access (1..15).
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: block can accept a request.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_addr_i` in 32: byte address (ALU result).
- `req_wdata_i` in 32: store data (RT data).
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: CPU consumes response.
- `rsp_rdata_o` out 32: load data (0 for stores and errors).
- `rsp_err_o` out 1: access was out of range (or misaligned, see Configuration).

## Operation
- FSM states, held in a 2-bit register:
  - IDLE: `req_ready_o` = 1.
  - BUSY: counter runs.
  - RESP: `rsp_valid_o` = 1.
- IDLE→BUSY on `req_valid_i & req_ready_o`:
  - latch we, addr, wdata.
  - load counter with LATENCY-1.
  - evaluate error.
- BUSY: decrement counter each cycle. At counter = 0, go to RESP.
- Exit edge of BUSY:
  - Store without error: write `mem[addr[log2(DEPTH)+1:2]]`.
  - Load without error: register the word into `rsp_rdata_o`.
- RESP→IDLE on `rsp_ready_i`. Hold `rsp_rdata_o`/`rsp_err_o` stable while `rsp_valid_o` = 1 and `rsp_ready_i` = 0.
- Error = `req_addr_i >= DEPTH*4`.
  - Erroring stores never modify memory.
  - Erroring loads return 0.
- `req_ready_o` is 0 outside IDLE. Requests in BUSY/RESP are ignored; the CPU holds them.
- Requests are strictly serialized: one outstanding access, no reordering.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `req_ready_o` = 1, `rsp_valid_o` = 0.
  - `rsp_rdata_o` = 0, `rsp_err_o` = 0.
  - Memory contents are not reset.
- Request accepted at edge N. `rsp_valid_o` rises after edge N+LATENCY.
- Minimum request-to-request interval: LATENCY+2 cycles when `rsp_ready_i` is held at 1.
- `rsp_ready_i` may be 1 before `rsp_valid_o`. The response is then consumed in its first RESP cycle and the FSM is in IDLE on the next cycle.
- Read-after-write to the same address in consecutive requests returns the new data; the write committed before the next request was accepted.
- `rst_i` asserted mid-BUSY: abort immediately and return to IDLE.
  - No write is committed unless the exit edge already occurred.
  - No response is issued.
- `rst_i` asserted in RESP: the response is dropped.
- `req_addr_i` bits [1:0] are ignored for indexing.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined: the error term also includes `req_addr_i[1:0] != 0`. A misaligned store is suppressed, and a misaligned load returns 0 with `rsp_err_o` = 1.
- Not defined: low address bits are silently dropped and only range errors are reported.

## Structure
- Shared package `dmem_pkg` holds:
  - state encoding (IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2).
  - word width 32 and byte-offset width 2.
  - the latency counter width constant 4.
- Sub-module `dmem_array`: synchronous single-port word RAM (write enable, index, wdata, registered rdata) with no reset. The FSM and counter stay in `dmem_responder`.

## Test plan
- Reset then store 0xDEADBEEF to 0x10, LATENCY=2:
  - `rsp_valid_o` rises 2 cycles after acceptance with `rsp_err_o` = 0 and `rsp_rdata_o` = 0.
  - Load 0x10 returns 0xDEADBEEF.
- Back-to-back stores to 0x0 and 0x4 with `rsp_ready_i` held at 1: the second request is accepted exactly LATENCY+2 cycles after the first, and both words read back correctly.
- Load with `rsp_ready_i` = 0 for 5 cycles: `rsp_valid_o`/`rsp_rdata_o` stay stable and `req_ready_o` stays 0. Raising `rsp_ready_i` returns the FSM to IDLE in 1 cycle.
- Store to 0x400 with DEPTH=256: `rsp_err_o` = 1, and no word in the array changes (check indices 0 and 255).
- With `DMEM_ALIGN_CHECK_EN`, store 0x55 to 0x6: `rsp_err_o` = 1 and `mem[1]` is unchanged. Without the macro, `mem[1]` = 0x55 and `rsp_err_o` = 0.
- Assert `rst_i` in the first BUSY cycle of a store to 0x20: no response, `req_ready_o` = 1 after reset, and a later load of 0x20 returns the prior value.
